// File: rtl/seg7_scan_decoder_pkg.sv
// Shared definitions for the 7-segment scan decoder: glyph table, segment
// bit order and the frame FSM state type.
package seg7_scan_decoder_pkg;

   // Segment bit order on the seg bus, MSB first.
   typedef struct packed {
      logic g;
      logic f;
      logic e;
      logic d;
      logic c;
      logic b;
      logic a;
   } seg_bits_t;

   localparam int SEG_W = $bits(seg_bits_t);

   // Active-low glyph patterns, {g,f,e,d,c,b,a}.
   localparam logic [SEG_W-1:0] GLYPH_0 = 7'b1000000;
   localparam logic [SEG_W-1:0] GLYPH_1 = 7'b1111001;
   localparam logic [SEG_W-1:0] GLYPH_2 = 7'b0100100;
   localparam logic [SEG_W-1:0] GLYPH_3 = 7'b0110000;
   localparam logic [SEG_W-1:0] GLYPH_4 = 7'b0011001;
   localparam logic [SEG_W-1:0] GLYPH_5 = 7'b0010010;
   localparam logic [SEG_W-1:0] GLYPH_6 = 7'b0000010;
   localparam logic [SEG_W-1:0] GLYPH_7 = 7'b1111000;
   localparam logic [SEG_W-1:0] GLYPH_8 = 7'b0000000;
   localparam logic [SEG_W-1:0] GLYPH_9 = 7'b0010000;
   localparam logic [SEG_W-1:0] GLYPH_A = 7'b0001000;
   localparam logic [SEG_W-1:0] GLYPH_B = 7'b0000011;
   localparam logic [SEG_W-1:0] GLYPH_C = 7'b1000110;
   localparam logic [SEG_W-1:0] GLYPH_D = 7'b0100001;
   localparam logic [SEG_W-1:0] GLYPH_E = 7'b0000110;
   localparam logic [SEG_W-1:0] GLYPH_F = 7'b0001110;

   localparam logic [15:0][SEG_W-1:0] GLYPHS = {
      GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
      GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
   };

   localparam logic [3:0]       AN_IDLE  = 4'hF;
   localparam logic [SEG_W-1:0] SEG_IDLE = 7'h7F;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational glyph lookup: maps an active-low segment pattern to its hex
// nibble; unknown patterns give nibble 0 with legal low.
module seg7_pattern_decode
   import seg7_scan_decoder_pkg::*;
(
   input  logic [SEG_W-1:0] seg,
   output logic [3:0]       nibble,
   output logic             legal
);

   always_comb begin
      nibble = 4'h0;
      legal  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (seg == GLYPHS[i]) begin
            nibble = 4'(i);
            legal  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a 4-digit hex frame from a multiplexed 7-segment display scan and
// presents it with a valid/ready handshake.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_COLLECT | capturing stable digits until all four flags are set
//   ST_PRESENT | frame_valid high, value/bad frozen, waiting for frame_ready
module seg7_scan_decoder
   import seg7_scan_decoder_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       an,
   input  logic [SEG_W-1:0] seg,
   input  logic             frame_ready,
   output logic             frame_valid,
   output logic [15:0]      value,
   output logic [3:0]       bad
);

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
   localparam logic [7:0] CNT_HIT = 8'(STABLE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [3:0]       an_q, an_p;
   logic [SEG_W-1:0] seg_q, seg_p;
   logic [7:0]       cnt;
   logic [3:0]       captured;
   logic             same;
   logic             one_low;
   logic             capture_hit;
   logic [3:0]       dec_nibble;
   logic             dec_legal;

   assign same    = ({an_q, seg_q} == {an_p, seg_p});
   assign one_low = ($countones(~an_p) == 1);

   // cnt sits at CNT_HIT for exactly one cycle per run, and an_p/seg_p then
   // hold the sample that made the run stable.
   assign capture_hit = (cnt == CNT_HIT) && one_low && (state_q == ST_COLLECT);

   seg7_pattern_decode u_decode (
      .seg    (seg_p),
      .nibble (dec_nibble),
      .legal  (dec_legal)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         an_q  <= AN_IDLE;
         seg_q <= SEG_IDLE;
         an_p  <= AN_IDLE;
         seg_p <= SEG_IDLE;
         cnt   <= 8'd0;
      end else begin
         an_q  <= an;
         seg_q <= seg;
         an_p  <= an_q;
         seg_p <= seg_q;
         if (same) begin
            if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
         end else begin
            cnt <= 8'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value    <= 16'h0000;
         bad      <= 4'b0000;
         captured <= 4'b0000;
      end else if ((state_q == ST_PRESENT) && frame_ready) begin
         captured <= 4'b0000;
      end else if (capture_hit) begin
         for (int i = 0; i < 4; i++) begin
            if (!an_p[i]) begin
               value[4*i +: 4] <= dec_nibble;
               bad[i]          <= ~dec_legal;
               captured[i]     <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_COLLECT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      frame_valid = 1'b0;
      case (state_q)
         ST_COLLECT: begin
            if (&captured) state_d = ST_PRESENT;
         end
         ST_PRESENT: begin
            frame_valid = 1'b1;
            if (frame_ready) state_d = ST_COLLECT;
         end
         default: state_d = ST_COLLECT;
      endcase
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus
// randomized scans checked against a per-digit frame model.
module tb_seg7_scan_decoder;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        frame_ready;
   logic        frame_valid;
   logic [15:0] value;
   logic [3:0]  bad;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
      .clk         (clk),
      .reset       (reset),
      .an          (an),
      .seg         (seg),
      .frame_ready (frame_ready),
      .frame_valid (frame_valid),
      .value       (value),
      .bad         (bad)
   );

   logic [6:0] glyph_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // Frame model: what each digit slot should hold after a scan.
   logic [15:0] m_val;
   logic [3:0]  m_bad;
   logic [3:0]  m_cap;
   logic [10:0] last_in;

   function automatic logic [3:0] sel(input int d);
      logic [3:0] one;
      one = 4'b0001 << d;
      return ~one;
   endfunction

   function automatic int zeros(input logic [3:0] a);
      int z = 0;
      for (int i = 0; i < 4; i++) if (a[i] == 1'b0) z++;
      return z;
   endfunction

   // {bad, nibble}
   function automatic logic [4:0] ref_decode(input logic [6:0] s);
      for (int i = 0; i < 16; i++) if (glyph_tab[i] == s) return {1'b0, 4'(i)};
      return 5'b10000;
   endfunction

   function automatic bit would_capture(input logic [3:0] a, input int n);
      return (n >= S) && (zeros(a) == 1);
   endfunction

   task automatic model_hold(input logic [3:0] a, input logic [6:0] s, input int n);
      logic [4:0] r;
      if (would_capture(a, n)) begin
         r = ref_decode(s);
         for (int d = 0; d < 4; d++) begin
            if (a[d] == 1'b0) begin
               m_val[4*d +: 4] = r[3:0];
               m_bad[d]        = r[4];
               m_cap[d]        = 1'b1;
            end
         end
      end
   endtask

   task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n,
                        output int first_fv);
      first_fv = -1;
      for (int j = 0; j < n; j++) begin
         an  = a;
         seg = s;
         @(posedge clk); #1;
         if (frame_valid && first_fv < 0) first_fv = j + 1;
      end
      last_in = {a, s};
   endtask

   task automatic wait_fv(input int budget, output int w, output bit found);
      w     = 0;
      found = frame_valid;
      while (!found && w < budget) begin
         @(posedge clk); #1;
         w++;
         found = frame_valid;
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      an          = 4'hF;
      seg         = 7'h7F;
      frame_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset   = 1'b0;
      m_val   = 16'h0;
      m_bad   = 4'h0;
      m_cap   = 4'h0;
      last_in = {4'hF, 7'h7F};
   endtask

   // Scans four digits; the last hold is extended until frame_valid shows.
   task automatic scan_frame(input logic [6:0] segs [4], input int hold,
                             output bit early, output bit found, output int lat);
      int f, w;
      early = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(sel(i), segs[i], hold, f);
         model_hold(sel(i), segs[i], hold);
         if (i < 3 && f >= 0) early = 1'b1;
      end
      if (f >= 0) begin
         found = 1'b1;
         lat   = f;
      end else begin
         wait_fv(30, w, found);
         lat = hold + w;
      end
   endtask

   task automatic consume();
      frame_ready = 1'b1;
      an  = 4'hF;
      seg = 7'h7F;
      @(posedge clk); #1;
      frame_ready = 1'b0;
      last_in = {4'hF, 7'h7F};
      m_cap   = 4'h0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", frame_valid); end
      vectors++; if (value !== 16'h0000)   begin miscompares++; $display("FAIL reset_value got %h want 0000", value); end
      vectors++; if (bad !== 4'b0000)      begin miscompares++; $display("FAIL reset_bad got %b want 0000", bad); end
   endtask

   task automatic test_basic();
      logic [6:0] s [4];
      bit early, found; int lat;
      do_reset();
      s = '{glyph_tab[4], glyph_tab[3], glyph_tab[2], glyph_tab[1]};
      scan_frame(s, 6, early, found, lat);
      vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL basic_early got %b want 0", early); end
      vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", found); end
      vectors++; if (lat < S + 2)    begin miscompares++; $display("FAIL basic_latency got %0d want >= %0d", lat, S + 2); end
      vectors++; if (value !== 16'h1234) begin miscompares++; $display("FAIL basic_value got %h want 1234", value); end
      vectors++; if (bad !== 4'b0000)    begin miscompares++; $display("FAIL basic_bad got %b want 0000", bad); end
      consume();
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL basic_release got %b want 0", frame_valid); end
      vectors++; if (value !== 16'h1234)   begin miscompares++; $display("FAIL basic_retain got %h want 1234", value); end
   endtask

   task automatic test_short_hold();
      bit seen = 1'b0; int f;
      do_reset();
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < 4; i++) begin
            drive(sel(i), glyph_tab[i + 1], S - 1, f);
            if (f >= 0) seen = 1'b1;
         end
      drive(4'hF, 7'h7F, 20, f);
      if (f >= 0) seen = 1'b1;
      vectors++; if (seen !== 1'b0)    begin miscompares++; $display("FAIL short_valid got %b want 0", seen); end
      vectors++; if (value !== 16'h0)  begin miscompares++; $display("FAIL short_value got %h want 0000", value); end
   endtask

   task automatic test_blank_digit();
      logic [6:0] s [4];
      bit early, found; int lat;
      do_reset();
      s = '{glyph_tab[15], glyph_tab[15], 7'h7F, glyph_tab[15]};
      scan_frame(s, 5, early, found, lat);
      vectors++; if (found !== 1'b1)     begin miscompares++; $display("FAIL blank_valid got %b want 1", found); end
      vectors++; if (value !== 16'hF0FF) begin miscompares++; $display("FAIL blank_value got %h want f0ff", value); end
      vectors++; if (bad !== 4'b0100)    begin miscompares++; $display("FAIL blank_bad got %b want 0100", bad); end
      consume();
   endtask

   task automatic test_illegal_select();
      logic [6:0] s [4];
      bit early, found; int lat, f;
      do_reset();
      drive(4'b1100, glyph_tab[8], 10, f);
      vectors++; if (value !== 16'h0) begin miscompares++; $display("FAIL illsel_value got %h want 0000", value); end
      s = '{glyph_tab[10], glyph_tab[11], glyph_tab[12], glyph_tab[13]};
      scan_frame(s, 6, early, found, lat);
      vectors++; if (found !== 1'b1)     begin miscompares++; $display("FAIL illsel_valid got %b want 1", found); end
      vectors++; if (value !== 16'hDCBA) begin miscompares++; $display("FAIL illsel_frame got %h want dcba", value); end
      consume();
   endtask

   task automatic test_backpressure();
      logic [6:0] s [4];
      bit early, found; int lat;
      do_reset();
      s = '{glyph_tab[4], glyph_tab[3], glyph_tab[2], glyph_tab[1]};
      scan_frame(s, 6, early, found, lat);
      for (int c = 0; c < 20; c++) begin
         an  = sel(c / 5);
         seg = glyph_tab[8 - c / 5];
         @(posedge clk); #1;
         vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid cycle %0d got %b want 1", c, frame_valid); end
         vectors++; if (value !== 16'h1234)   begin miscompares++; $display("FAIL bp_hold_value cycle %0d got %h want 1234", c, value); end
      end
      consume();
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release got %b want 0", frame_valid); end
      vectors++; if (value !== 16'h1234)   begin miscompares++; $display("FAIL bp_retain got %h want 1234", value); end
      s = '{glyph_tab[8], glyph_tab[7], glyph_tab[6], glyph_tab[5]};
      scan_frame(s, 6, early, found, lat);
      vectors++; if (found !== 1'b1)     begin miscompares++; $display("FAIL bp_next_valid got %b want 1", found); end
      vectors++; if (value !== 16'h5678) begin miscompares++; $display("FAIL bp_next_value got %h want 5678", value); end
      // reset while a frame is presented must drop it
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL bp_reset_valid got %b want 0", frame_valid); end
      vectors++; if (value !== 16'h0)      begin miscompares++; $display("FAIL bp_reset_value got %h want 0000", value); end
   endtask

   task automatic test_reset_midframe();
      logic [6:0] s [4];
      bit early, found; int lat, f;
      do_reset();
      for (int i = 0; i < 3; i++) drive(sel(i), glyph_tab[9 - i], 6, f);
      drive(4'hF, 7'h7F, 3, f);
      do_reset();
      drive(sel(3), glyph_tab[6], 30, f);
      vectors++; if (f >= 0) begin miscompares++; $display("FAIL midreset_partial got valid at %0d want none", f); end
      s = '{glyph_tab[9], glyph_tab[8], glyph_tab[7], glyph_tab[6]};
      scan_frame(s, 6, early, found, lat);
      vectors++; if (found !== 1'b1)     begin miscompares++; $display("FAIL midreset_valid got %b want 1", found); end
      vectors++; if (value !== 16'h6789) begin miscompares++; $display("FAIL midreset_value got %h want 6789", value); end
      consume();
   endtask

   task automatic test_random();
      logic [3:0] a; logic [6:0] s; int n, f, w, steps; bit found, done;
      do_reset();
      for (int fr = 0; fr < 6; fr++) begin
         done  = 1'b0;
         steps = 0;
         while (!done && steps < 200) begin
            steps++;
            do begin
               a = ($urandom_range(0, 5) == 0) ? 4'($urandom) : sel($urandom_range(0, 3));
               s = ($urandom_range(0, 4) == 0) ? 7'($urandom) : glyph_tab[$urandom_range(0, 15)];
            end while ({a, s} == last_in);
            n = $urandom_range(1, S + 3);
            if (would_capture(a, n) && ((m_cap | ~a) == 4'hF)) begin
               frame_ready = 1'b0;
               drive(a, s, n, f);
               model_hold(a, s, n);
               if (f < 0) begin
                  wait_fv(30, w, found);
                  f = n + w;
               end else found = 1'b1;
               vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL rnd_valid frame %0d got 0 want 1", fr); end
               vectors++; if (f < S + 2)      begin miscompares++; $display("FAIL rnd_latency frame %0d got %0d want >= %0d", fr, f, S + 2); end
               vectors++; if (value !== m_val) begin miscompares++; $display("FAIL rnd_value frame %0d got %h want %h", fr, value, m_val); end
               vectors++; if (bad !== m_bad)   begin miscompares++; $display("FAIL rnd_bad frame %0d got %b want %b", fr, bad, m_bad); end
               consume();
               vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_release frame %0d got 1 want 0", fr); end
               done = 1'b1;
            end else begin
               frame_ready = 1'($urandom);
               drive(a, s, n, f);
               model_hold(a, s, n);
               vectors++; if (f >= 0) begin miscompares++; $display("FAIL rnd_early frame %0d step %0d got valid want 0", fr, steps); end
            end
         end
         frame_ready = 1'b0;
         if (!done) begin
            vectors++; miscompares++;
            $display("FAIL rnd_budget frame %0d got incomplete want complete", fr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short_hold();
      test_blank_digit();
      test_illegal_select();
      test_backpressure();
      test_reset_midframe();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
